// File: rtl/pcie_mailbox_writer.sv
// pcie_mailbox_writer: buffers PCIe mailbox messages in a small FIFO and writes each one into its
// thread's RAM slot, body words first and toggled header last. MBOX_WR_STATS_EN adds msg_count.
//
// state | meaning
// IDLE  | waiting for a message; pops the FIFO head into the working register
// BODY  | writing body words 1..NWORDS-1 to the slot
// HDR   | writing header word 0 with the flipped toggle, pulsing msg_done
module pcie_mailbox_writer #(
    parameter int NTHREAD    = 64,
    parameter int DATA_W     = 128,
    parameter int WORD_W     = 32,
    parameter int SLOT_WORDS = 16,
    parameter int ADDR_W     = 11,
    parameter int TID_LSB    = 102,
    parameter int FIFO_DEPTH = 4,
    localparam int TIDW      = $clog2(NTHREAD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ram_stall,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    output logic              msg_done,
    output logic [TIDW-1:0]   msg_tid,
    output logic              busy,
    output logic [31:0]       msg_count
);
    localparam int NWORDS  = DATA_W / WORD_W;
    localparam int KW      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int SLOT_SH = $clog2(SLOT_WORDS);
    localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BODY, HDR} state_t;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic [PW:0]       count_nxt;
    logic              full;
    logic              push;
    logic              pop;

    state_t            state;
    logic [DATA_W-1:0] msg_q;
    logic [TIDW-1:0]   tid;
    logic [KW-1:0]     k;
    logic [NTHREAD-1:0] toggle;
    logic [WORD_W-1:0] body_w [NWORDS];
    logic [ADDR_W-1:0] slot_base;
    logic              busy_nxt;
    logic              unused_msb;

    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
    assign slot_base = ADDR_W'(tid) << SLOT_SH;
    // The message MSB is replaced by the toggle bit in the header.
    assign unused_msb = msg_q[DATA_W-1];

    assign body_w[0] = '0;
    for (genvar i = 1; i < NWORDS; i++) begin : g_body
        assign body_w[i] = msg_q[DATA_W-1-i*WORD_W -: WORD_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= in_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_comb begin
        busy_nxt = (count_nxt != '0);
        case (state)
            IDLE:    if (pop) busy_nxt = 1'b1;
            BODY:    busy_nxt = 1'b1;
            HDR:     if (ram_stall) busy_nxt = 1'b1;
            default: busy_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            msg_q     <= '0;
            tid       <= '0;
            k         <= '0;
            toggle    <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            msg_done  <= 1'b0;
            msg_tid   <= '0;
            busy      <= 1'b0;
        end else begin
            busy <= busy_nxt;
            case (state)
                IDLE: begin
                    ram_we   <= 1'b0;
                    msg_done <= 1'b0;
                    if (pop) begin
                        msg_q <= fifo_mem[rd_ptr];
                        tid   <= fifo_mem[rd_ptr][TID_LSB +: TIDW];
                        k     <= KW'(1);
                        state <= (NWORDS == 1) ? HDR : BODY;
                    end
                end
                BODY: begin
                    msg_done <= 1'b0;
                    ram_we   <= !ram_stall;
                    if (!ram_stall) begin
                        ram_addr  <= slot_base | ADDR_W'(k);
                        ram_wdata <= body_w[k];
                        k         <= k + 1'b1;
                        if (k == KW'(NWORDS-1)) state <= HDR;
                    end
                end
                HDR: begin
                    ram_we   <= !ram_stall;
                    msg_done <= !ram_stall;
                    if (!ram_stall) begin
                        ram_addr    <= slot_base;
                        ram_wdata   <= {~toggle[tid], msg_q[DATA_W-2 -: WORD_W-1]};
                        toggle[tid] <= ~toggle[tid];
                        msg_tid     <= tid;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MBOX_WR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) msg_count <= '0;
        else if (state == HDR && !ram_stall) msg_count <= msg_count + 32'd1;
    end
`else
    assign msg_count = '0;
`endif

endmodule

// File: tb/tb_pcie_mailbox_writer.sv
// Scoreboard bench for pcie_mailbox_writer: stimulus queues expected RAM writes, a negedge
// monitor pops and compares them whenever ram_we is seen.
module tb_pcie_mailbox_writer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         ram_stall = 1'b0;
    logic         ram_we;
    logic [10:0]  ram_addr;
    logic [31:0]  ram_wdata;
    logic         msg_done;
    logic [5:0]   msg_tid;
    logic         busy;
    logic [31:0]  msg_count;

    typedef struct {
        logic [10:0] a;
        logic [31:0] d;
        logic        hdr;
        logic [5:0]  tid;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] tog = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          stall_writes = 0;
    logic        stall_chk = 1'b0;

    pcie_mailbox_writer dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ram_stall(ram_stall), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .msg_done(msg_done), .msg_tid(msg_tid), .busy(busy), .msg_count(msg_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic exp_word(input logic [10:0] a, input logic [31:0] d, input logic hdr,
                            input logic [5:0] tid);
        exp_t e;
        e.a = a; e.d = d; e.hdr = hdr; e.tid = tid;
        exp_q.push_back(e);
    endtask

    task automatic exp_lit(input logic [5:0] tid, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] w3, input logic [31:0] hdr);
        logic [10:0] base;
        base = 11'(tid) << 4;
        exp_word(base + 11'd1, w1, 1'b0, tid);
        exp_word(base + 11'd2, w2, 1'b0, tid);
        exp_word(base + 11'd3, w3, 1'b0, tid);
        exp_word(base, hdr, 1'b1, tid);
        tog[tid] = ~tog[tid];
    endtask

    task automatic exp_from(input logic [127:0] d);
        logic [5:0] tid;
        tid = d[107:102];
        exp_lit(tid, d[95:64], d[63:32], d[31:0], {~tog[tid], d[126:96]});
    endtask

    function automatic logic [127:0] mk(input int i);
        logic [127:0] v;
        v = {32'hA500_0000 + 32'(i), 32'h1000_0000 + 32'(i),
             32'h2000_0000 + 32'(i), 32'h3000_0000 + 32'(i)};
        v[107:102] = 6'(i + 20);
        return v;
    endfunction

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic push(input logic [127:0] d);
        int t = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("push_accept", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || ram_we || exp_q.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_in_time", 64'(t < 1000), 64'(1));
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (stall_chk && ram_we) stall_writes++;
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", ram_addr, ram_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(ram_addr), 64'(e.a));
                chk("wr_data", 64'(ram_wdata), 64'(e.d));
                chk("wr_msg_done", 64'(msg_done), 64'(e.hdr));
                if (e.hdr) chk("wr_msg_tid", 64'(msg_tid), 64'(e.tid));
            end
        end else if (msg_done === 1'b1) begin
            n_checks++;
            $display("FAIL stray_msg_done: msg_done 1 with ram_we 0, required 0");
        end
    end

    initial begin
        logic [127:0] d;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_ram_we", 64'(ram_we), 64'(0));
        chk("rst_ram_addr", 64'(ram_addr), 64'(0));
        chk("rst_ram_wdata", 64'(ram_wdata), 64'(0));
        chk("rst_msg_done", 64'(msg_done), 64'(0));
        chk("rst_msg_tid", 64'(msg_tid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_msg_count", 64'(msg_count), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        // tid 5 in bits 107:102 replaces the low bits of the top word (0x321 -> 0x161)
        exp_lit(6'd5, 32'h0000_0011, 32'h2222_2222, 32'h3333_3333, 32'h8765_4161);
        push(128'h8765_4161_0000_0011_2222_2222_3333_3333);
        @(negedge clk);
        chk("latency_e1_we", 64'(ram_we), 64'(0));
        @(negedge clk);
        chk("latency_e2_we", 64'(ram_we), 64'(1));
        wait_idle();

        // Same tid back-to-back: header MSB 0 then 1, regardless of the message MSB
        exp_lit(6'd5, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'h0000_0140);
        push(128'h8000_0140_AAAA_AAAA_BBBB_BBBB_CCCC_CCCC);
        exp_lit(6'd5, 32'h1111_1111, 32'h4444_4444, 32'h5555_5555, 32'hFFFF_F17F);
        push(128'h7FFF_F17F_1111_1111_4444_4444_5555_5555);
        wait_idle();
`ifdef MBOX_WR_STATS_EN
        chk("msg_count_3", 64'(msg_count), 64'(3));
`else
        chk("msg_count_off", 64'(msg_count), 64'(0));
`endif

        // Flow control under a held stall
        ram_stall = 1'b1;
        stall_chk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = mk(i);
            exp_from(d);
            push(d);
        end
        chk("full_in_ready", 64'(in_ready), 64'(0));
        d = mk(5);
        exp_from(d);
        in_data  = d;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold_in_ready", 64'(in_ready), 64'(0));
        end
        stall_chk = 1'b0;
        ram_stall = 1'b0;
        push(d);
        wait_idle();

        // Stall for three edges before word 2 of a tid 9 message
        exp_lit(6'd9, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h8000_0240);
        push(128'h0000_0240_0101_0101_0202_0202_0303_0303);
        @(negedge clk);
        @(negedge clk);
        ram_stall = 1'b1;
        @(negedge clk);
        stall_chk = 1'b1;
        @(negedge clk);
        chk("stall_addr_hold", 64'(ram_addr), 64'(145));
        chk("stall_busy", 64'(busy), 64'(1));
        @(negedge clk);
        ram_stall = 1'b0;
        stall_chk = 1'b0;
        wait_idle();

        // Reset after body word 1 of a tid 12 message
        exp_word(11'd193, 32'h0C0C_0C0C, 1'b0, 6'd12);
        push(128'h0000_0300_0C0C_0C0C_0D0D_0D0D_0E0E_0E0E);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        tog = '0;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        chk("mid_rst_ram_we", 64'(ram_we), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_in_ready", 64'(in_ready), 64'(1));
        chk("after_rst_busy", 64'(busy), 64'(0));
        exp_lit(6'd12, 32'h1C1C_1C1C, 32'h1D1D_1D1D, 32'h1E1E_1E1E, 32'h8000_0300);
        push(128'h0000_0300_1C1C_1C1C_1D1D_1D1D_1E1E_1E1E);
        wait_idle();

        // Highest thread ID: slot 1008..1023
        exp_lit(6'd63, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_F00D, 32'h9234_5FC5);
        push(128'h1234_5FC5_DEAD_BEEF_0BAD_F00D_CAFE_F00D);
        wait_idle();

`ifdef MBOX_WR_STATS_EN
        chk("msg_count_final", 64'(msg_count), 64'(2));
`else
        chk("msg_count_final", 64'(msg_count), 64'(0));
`endif
        chk("exp_queue_empty", 64'(exp_q.size()), 64'(0));
        chk("writes_during_stall", 64'(stall_writes), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
